exec_control: RTL and testbench
===============================

EXEC_CONTROL -- requirements
Module: exec_control

Interface
REQ-001 Parameter: DATA_W, default 8, datapath/register/PC width.
REQ-002 Parameter: NREGS, default 4, register-file entries (index width 2).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: instr_valid  input  1  instruction word present on instr.
REQ-006 Port: instr  input  16  [15:12] opcode, [11:10] rd/rs1, [9:8] rs/rs2, [7:6] rt, [7:0] imm.
REQ-007 Port: instr_ready  output  1  block accepts an instruction this cycle.
REQ-008 Port: alu_a, alu_b  output  8 each  ALU operands.
REQ-009 Port: alu_opcode  output  4  ALU operation select.
REQ-010 Port: alu_result  input  8  combinational ALU result for current alu_a/alu_b/alu_opcode.
REQ-011 Port: alu_zero  input  1  alu_result == 0.
REQ-012 Port: pc  output  8  current program counter.
REQ-013 Port: retire  output  1  one-cycle pulse, instruction completed.
REQ-014 Port: branch_taken  output  1  one-cycle pulse coincident with retire of a taken branch.
REQ-015 Port: dbg_rsel  input  2 / dbg_rdata  output  8  combinational register-file read for benches.

Function
REQ-016 FSM states IDLE, EXEC, WB; IDLE->EXEC on instr_valid && instr_ready; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-017 instr_ready = 1 only in IDLE; instr latched into an internal register on acceptance; instr_valid in EXEC/WB ignored.
REQ-018 Fixed latency: accept in cycle N, ALU driven in N+1, writeback/pc update/retire in N+2, next accept earliest N+3.
REQ-019 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 1001 ADDI, 1011 BEQ, 1100 BNE; all others NOP.
REQ-020 EXEC, R-type (0000-0101): alu_a = R[rs], alu_b = R[rt], alu_opcode = instruction opcode.
REQ-021 EXEC, ADDI: alu_a = R[rs], alu_b = imm; BEQ/BNE: alu_a = R[rs1], alu_b = R[rs2].
REQ-022 Outside EXEC, and in EXEC for NOP: alu_a = 0, alu_b = 0, alu_opcode = 4'b1111.
REQ-023 alu_result and alu_zero registered at end of EXEC; WB acts only on registered copies.
REQ-024 WB, R-type/ADDI: R[rd] <= captured result; writes to rd = 0 discarded (R0 reads 0 always).
REQ-025 WB, BEQ taken iff captured zero = 1; BNE taken iff captured zero = 0; branches never write registers.
REQ-026 WB pc update: taken branch pc <= pc + imm (imm signed two's complement); otherwise pc <= pc + 1; modulo 256, 255+1 = 0.
REQ-027 retire = 1 exactly in WB cycle for every accepted instruction, NOP included; branch_taken = 1 only there.
REQ-028 Register reads in EXEC see the preceding instruction's writeback (no hazard, no bypass needed).

Reset
REQ-029 rst sampled high: state <= IDLE, pc <= 0, all registers <= 0, captured result/zero <= 0, latched instr <= NOP.
REQ-030 While rst high: instr_ready = 0, retire = 0, branch_taken = 0, alu outputs at REQ-022 idle values.
REQ-031 rst in EXEC or WB aborts instruction: no register write, no pc update, no retire.
REQ-032 First cycle after rst deasserts: IDLE, instr_ready = 1.

Structure
REQ-033 Package cpu_pkg holds: opcode constants (shared with ALU), FSM state enum, DATA_W, instruction field positions.
REQ-034 Register file is sub-module reg_file_4x8: two async read ports + dbg read port, one sync write port, R0 hardwired 0.
REQ-035 All registers in exec_control reset synchronously per REQ-029; no latches.

Verification
REQ-036 ADDI r1,r0,5 then ADDI r2,r0,3 then SUB r3,r1,r2 -> dbg R3 = 2, retire once per instr, pc = 3.
REQ-037 SLT r3,r2,r1 (3<5) -> R3 = 1; SLT r3,r1,r2 -> R3 = 0; ADD r0,r1,r1 -> R0 stays 0.
REQ-038 pc = 10, R1 = R2 = 7, BEQ r1,r2,imm=0xFC -> branch_taken pulse, pc = 6; BNE same operands -> pc = 11, no pulse.
REQ-039 pc = 255, NOP (opcode 0111) -> retire, pc = 0, no register change; instr_valid held high -> ready high only every third cycle.
REQ-040 rst asserted in EXEC of ADDI r1,r0,9 -> R1 = 0, pc = 0, no retire, instr_ready = 1 first cycle after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the execution controller and its ALU.
//   - DATA_W / INSTR_W / REG_AW: datapath, instruction and register-index widths
//   - instruction field positions
//   - opcode constants (the external ALU decodes the same values)
//   - FSM state encoding
//   - opcode classification helpers
package cpu_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned REG_AW  = 2;
   localparam int unsigned OPC_W   = 4;

   // Instruction field positions
   localparam int unsigned OPC_HI = 15;
   localparam int unsigned OPC_LO = 12;
   localparam int unsigned RD_HI  = 11;
   localparam int unsigned RD_LO  = 10;
   localparam int unsigned RS_HI  = 9;
   localparam int unsigned RS_LO  = 8;
   localparam int unsigned RT_HI  = 7;
   localparam int unsigned RT_LO  = 6;
   localparam int unsigned IMM_HI = 7;
   localparam int unsigned IMM_LO = 0;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam opcode_t OP_ADD  = 4'b0000;
   localparam opcode_t OP_SUB  = 4'b0001;
   localparam opcode_t OP_AND  = 4'b0010;
   localparam opcode_t OP_OR   = 4'b0011;
   localparam opcode_t OP_XOR  = 4'b0100;
   localparam opcode_t OP_SLT  = 4'b0101;
   localparam opcode_t OP_ADDI = 4'b1001;
   localparam opcode_t OP_BEQ  = 4'b1011;
   localparam opcode_t OP_BNE  = 4'b1100;
   localparam opcode_t OP_NOP  = 4'b1111;

   // ALU select presented whenever no operation is being executed
   localparam opcode_t ALU_IDLE = 4'b1111;

   localparam logic [INSTR_W-1:0] INSTR_NOP = {OP_NOP, 12'h000};

   // FSM states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_WB   = 2'd2;

   function automatic logic is_rtype(input opcode_t op);
      return op <= OP_SLT;
   endfunction

   function automatic logic is_addi(input opcode_t op);
      return op == OP_ADDI;
   endfunction

   function automatic logic is_branch(input opcode_t op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic writes_reg(input opcode_t op);
      return is_rtype(op) || is_addi(op);
   endfunction

   // Anything not recognised executes as a NOP
   function automatic logic is_active(input opcode_t op);
      return writes_reg(op) || is_branch(op);
   endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// reg_file_4x8: small register file with R0 hardwired to zero.
//   clk, rst          : clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata    : synchronous write port (writes to R0 are dropped)
//   raddr_a/rdata_a   : asynchronous read port A
//   raddr_b/rdata_b   : asynchronous read port B
//   dbg_rsel/dbg_rdata: asynchronous debug read port
module reg_file_4x8
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned NREGS  = 4,
   parameter int unsigned AW     = cpu_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [AW-1:0]     dbg_rsel,
   output logic [DATA_W-1:0] dbg_rdata
);

   logic [DATA_W-1:0] regs [NREGS];

   // Storage; index 0 is never written outside reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Reads of R0 forced to zero independent of storage contents
   assign rdata_a   = (raddr_a  == '0) ? '0 : regs[raddr_a];
   assign rdata_b   = (raddr_b  == '0) ? '0 : regs[raddr_b];
   assign dbg_rdata = (dbg_rsel == '0) ? '0 : regs[dbg_rsel];

endmodule

// File: rtl/exec_control.sv
// exec_control: three-state (IDLE/EXEC/WB) instruction sequencer driving an
// external combinational ALU and a 4-entry register file.
//   clk, rst              : clock, synchronous active-high reset
//   instr_valid/instr     : instruction offer; accepted when instr_ready is high
//   instr_ready           : high only in IDLE (and not in reset)
//   alu_a/alu_b/alu_opcode: ALU operands/select, live only in EXEC
//   alu_result/alu_zero   : ALU response, captured at the end of EXEC
//   pc                    : program counter, updated in WB
//   retire/branch_taken   : one-cycle pulses in WB
//   dbg_rsel/dbg_rdata    : combinational register-file peek
module exec_control #(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned NREGS  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       instr_valid,
   input  logic [15:0]                instr,
   output logic                       instr_ready,
   output logic [DATA_W-1:0]          alu_a,
   output logic [DATA_W-1:0]          alu_b,
   output logic [3:0]                 alu_opcode,
   input  logic [DATA_W-1:0]          alu_result,
   input  logic                       alu_zero,
   output logic [DATA_W-1:0]          pc,
   output logic                       retire,
   output logic                       branch_taken,
   input  logic [cpu_pkg::REG_AW-1:0] dbg_rsel,
   output logic [DATA_W-1:0]          dbg_rdata
);

   import cpu_pkg::*;

   state_t               state;
   state_t               state_d;
   logic [INSTR_W-1:0]   ir;
   logic [DATA_W-1:0]    res_q;
   logic                 zero_q;

   opcode_t              op;
   logic [REG_AW-1:0]    rd;
   logic [REG_AW-1:0]    rs;
   logic [REG_AW-1:0]    rt;
   logic [7:0]           imm;

   logic                 accept_c;
   logic                 taken_c;
   logic                 we_c;
   logic [REG_AW-1:0]    ra_addr;
   logic [REG_AW-1:0]    rb_addr;
   logic [DATA_W-1:0]    ra_data;
   logic [DATA_W-1:0]    rb_data;
   logic [DATA_W-1:0]    pc_next;

   // Field decode of the latched instruction
   assign op  = ir[OPC_HI:OPC_LO];
   assign rd  = ir[RD_HI:RD_LO];
   assign rs  = ir[RS_HI:RS_LO];
   assign rt  = ir[RT_HI:RT_LO];
   assign imm = ir[IMM_HI:IMM_LO];

   assign instr_ready = !rst && (state == ST_IDLE);
   assign accept_c    = instr_valid && instr_ready;

   // Branches compare rs1/rs2 ([11:10]/[9:8]); everything else reads rs/rt
   assign ra_addr = is_branch(op) ? rd : rs;
   assign rb_addr = is_branch(op) ? rs : rt;

   assign taken_c = ((op == OP_BEQ) && zero_q) || ((op == OP_BNE) && !zero_q);
   assign pc_next = taken_c ? (pc + DATA_W'($signed(imm))) : (pc + DATA_W'(1));

   // Reset in WB must suppress the write even though the array is also cleared
   assign we_c = !rst && (state == ST_WB) && writes_reg(op);

   reg_file_4x8 #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (REG_AW)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .we        (we_c),
      .waddr     (rd),
      .wdata     (res_q),
      .raddr_a   (ra_addr),
      .rdata_a   (ra_data),
      .raddr_b   (rb_addr),
      .rdata_b   (rb_data),
      .dbg_rsel  (dbg_rsel),
      .dbg_rdata (dbg_rdata)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_d      = state;
      alu_a        = '0;
      alu_b        = '0;
      alu_opcode   = ALU_IDLE;
      retire       = 1'b0;
      branch_taken = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_WB;
            if (!rst && is_active(op)) begin
               alu_opcode = op;
               alu_a      = ra_data;
               alu_b      = is_addi(op) ? DATA_W'(imm) : rb_data;
            end
         end
         ST_WB: begin
            state_d      = ST_IDLE;
            retire       = !rst;
            branch_taken = !rst && taken_c;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Instruction latch, ALU capture and program counter
   always_ff @(posedge clk) begin
      if (rst) begin
         ir     <= INSTR_NOP;
         res_q  <= '0;
         zero_q <= 1'b0;
         pc     <= '0;
      end else begin
         if (accept_c) begin
            ir <= instr;
         end
         if (state == ST_EXEC) begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
         end
         if (state == ST_WB) begin
            pc <= pc_next;
         end
      end
   end

endmodule

// File: tb/tb_exec_control.sv
// tb_exec_control: self-checking bench for exec_control with a behavioural
// ALU and an ISA-level reference model feeding an expected-result queue.
module tb_exec_control;

   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic [15:0] instr;
   logic       instr_ready;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_opcode;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic [7:0] pc;
   logic       retire;
   logic       branch_taken;
   logic [1:0] dbg_rsel;
   logic [7:0] dbg_rdata;

   int checks = 0;
   int errors = 0;
   int n_retire = 0;

   typedef struct {
      logic [7:0] pc;
      logic       taken;
      logic       wr;
      logic [1:0] rd;
      logic [7:0] val;
      logic [3:0] aop;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_regs [4];
   logic [7:0] m_pc;

   always #5 clk = ~clk;

   exec_control #(.DATA_W(8), .NREGS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_ready  (instr_ready),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_opcode   (alu_opcode),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .pc           (pc),
      .retire       (retire),
      .branch_taken (branch_taken),
      .dbg_rsel     (dbg_rsel),
      .dbg_rdata    (dbg_rdata)
   );

   // Behavioural ALU
   always_comb begin
      case (alu_opcode)
         OP_ADD, OP_ADDI:        alu_result = alu_a + alu_b;
         OP_SUB, OP_BEQ, OP_BNE: alu_result = alu_a - alu_b;
         OP_AND:                 alu_result = alu_a & alu_b;
         OP_OR:                  alu_result = alu_a | alu_b;
         OP_XOR:                 alu_result = alu_a ^ alu_b;
         OP_SLT:                 alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
         default:                alu_result = 8'd0;
      endcase
   end
   assign alu_zero = (alu_result == 8'd0);

   always @(posedge clk) begin
      if (retire) n_retire <= n_retire + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [1:0] rt);
      return {op, rd, rs, rt, 6'b000000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // ISA-level reference for one instruction against the model state
   function automatic exp_t predict(input logic [15:0] iw);
      exp_t       e;
      logic [3:0] op;
      logic [1:0] f_rd, f_rs, f_rt;
      logic [7:0] imm;
      op   = iw[15:12];
      f_rd = iw[11:10];
      f_rs = iw[9:8];
      f_rt = iw[7:6];
      imm  = iw[7:0];
      e.pc = m_pc + 8'd1; e.taken = 1'b0; e.wr = 1'b0; e.rd = f_rd;
      e.val = 8'd0; e.aop = 4'hF; e.a = 8'd0; e.b = 8'd0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
            e.a = m_regs[f_rs]; e.b = m_regs[f_rt]; e.aop = op; e.wr = 1'b1;
            case (op)
               OP_ADD:  e.val = e.a + e.b;
               OP_SUB:  e.val = e.a - e.b;
               OP_AND:  e.val = e.a & e.b;
               OP_OR:   e.val = e.a | e.b;
               OP_XOR:  e.val = e.a ^ e.b;
               default: e.val = ($signed(e.a) < $signed(e.b)) ? 8'd1 : 8'd0;
            endcase
         end
         OP_ADDI: begin
            e.a = m_regs[f_rs]; e.b = imm; e.aop = op; e.wr = 1'b1; e.val = e.a + imm;
         end
         OP_BEQ, OP_BNE: begin
            e.a = m_regs[f_rd]; e.b = m_regs[f_rs]; e.aop = op;
            e.taken = (op == OP_BEQ) ? (e.a == e.b) : (e.a != e.b);
            if (e.taken) e.pc = m_pc + imm;
         end
         default: ;
      endcase
      return e;
   endfunction

   // Issue one instruction, then pop the scoreboard when it retires
   task automatic run_instr(input logic [15:0] iw, output logic bt);
      exp_t e, g;
      int   n;
      e = predict(iw);
      exp_q.push_back(e);
      bt = 1'b0;
      n = 0;
      while (instr_ready !== 1'b1 && n < 8) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("FAIL ready_wait: instr_ready=%b expected 1", instr_ready);
      end
      instr_valid = 1'b1; instr = iw;
      @(posedge clk); #1;
      // EXEC: keep offering a different instruction; it must be ignored
      instr = 16'h94FF;
      #1;
      checks++;
      if ({alu_opcode, alu_a, alu_b} !== {e.aop, e.a, e.b}) begin
         errors++;
         $display("FAIL alu_operands iw=%h: op=%h a=%h b=%h expected op=%h a=%h b=%h",
                  iw, alu_opcode, alu_a, alu_b, e.aop, e.a, e.b);
      end
      checks++;
      if (instr_ready !== 1'b0) begin
         errors++; $display("FAIL ready_in_exec: instr_ready=%b expected 0", instr_ready);
      end
      n = 1;
      while (retire !== 1'b1 && n < 6) begin
         @(posedge clk); #1; n++; instr_valid = 1'b0;
      end
      instr_valid = 1'b0;
      checks++;
      if (retire !== 1'b1 || n != 2) begin
         errors++; $display("FAIL retire_latency iw=%h: retire=%b cycles=%0d expected 1 at 2", iw, retire, n);
      end
      g = exp_q.pop_front();
      bt = branch_taken;
      checks++;
      if (branch_taken !== g.taken) begin
         errors++; $display("FAIL branch_taken iw=%h: got %b expected %b", iw, branch_taken, g.taken);
      end
      if (g.wr && g.rd != 2'd0) m_regs[g.rd] = g.val;
      m_pc = g.pc;
      @(posedge clk); #1;
      checks++;
      if (pc !== g.pc) begin
         errors++; $display("FAIL pc_update iw=%h: pc=%h expected %h", iw, pc, g.pc);
      end
      if (g.wr) begin
         dbg_rsel = g.rd; #1;
         checks++;
         if (dbg_rdata !== ((g.rd == 2'd0) ? 8'd0 : g.val)) begin
            errors++; $display("FAIL reg_write iw=%h: R%0d=%h expected %h", iw, g.rd, dbg_rdata,
                               (g.rd == 2'd0) ? 8'd0 : g.val);
         end
      end
   endtask

   // Move pc to a target with a taken BEQ r0,r0
   task automatic goto_pc(input logic [7:0] target);
      logic bt;
      if (m_pc != target) run_instr(enc_i(OP_BEQ, 2'd0, 2'd0, target - m_pc), bt);
   endtask

   task automatic test_reset();
      rst = 1'b1; instr_valid = 1'b1; instr = enc_i(OP_ADDI, 2'd1, 2'd0, 8'h11); dbg_rsel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({instr_ready, retire, branch_taken} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: ready/retire/taken=%b expected 000",
                            {instr_ready, retire, branch_taken});
      end
      checks++;
      if ({alu_opcode, alu_a, alu_b} !== {4'hF, 8'h00, 8'h00}) begin
         errors++; $display("FAIL reset_alu: op=%h a=%h b=%h expected f 00 00", alu_opcode, alu_a, alu_b);
      end
      checks++;
      if (pc !== 8'd0) begin
         errors++; $display("FAIL reset_pc: pc=%h expected 00", pc);
      end
      instr_valid = 1'b0; rst = 1'b0; #1;
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: instr_ready=%b expected 1", instr_ready);
      end
      for (int i = 0; i < 4; i++) begin
         dbg_rsel = 2'(i); #1;
         checks++;
         if (dbg_rdata !== 8'd0) begin
            errors++; $display("FAIL reset_reg R%0d: got %h expected 00", i, dbg_rdata);
         end
         m_regs[i] = 8'd0;
      end
      m_pc = 8'd0;
   endtask

   task automatic test_arith();
      logic bt;
      int   base;
      base = n_retire;
      run_instr(enc_i(OP_ADDI, 2'd1, 2'd0, 8'd5), bt);
      run_instr(enc_i(OP_ADDI, 2'd2, 2'd0, 8'd3), bt);
      run_instr(enc_r(OP_SUB, 2'd3, 2'd1, 2'd2), bt);
      dbg_rsel = 2'd3; #1;
      checks++;
      if (dbg_rdata !== 8'd2) begin
         errors++; $display("FAIL arith_r3: got %h expected 02", dbg_rdata);
      end
      checks++;
      if (pc !== 8'd3 || (n_retire - base) != 3) begin
         errors++; $display("FAIL arith_pc_retire: pc=%h retires=%0d expected 03 and 3", pc, n_retire - base);
      end
   endtask

   task automatic test_slt();
      logic bt;
      run_instr(enc_r(OP_SLT, 2'd3, 2'd2, 2'd1), bt);
      dbg_rsel = 2'd3; #1;
      checks++;
      if (dbg_rdata !== 8'd1) begin
         errors++; $display("FAIL slt_true: got %h expected 01", dbg_rdata);
      end
      run_instr(enc_r(OP_SLT, 2'd3, 2'd1, 2'd2), bt);
      dbg_rsel = 2'd3; #1;
      checks++;
      if (dbg_rdata !== 8'd0) begin
         errors++; $display("FAIL slt_false: got %h expected 00", dbg_rdata);
      end
      run_instr(enc_r(OP_ADD, 2'd0, 2'd1, 2'd1), bt);
      dbg_rsel = 2'd0; #1;
      checks++;
      if (dbg_rdata !== 8'd0) begin
         errors++; $display("FAIL r0_hardwired: got %h expected 00", dbg_rdata);
      end
   endtask

   task automatic test_random_alu();
      logic       bt;
      logic [3:0] ops [7];
      logic [3:0] op;
      ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
      ops[4] = OP_XOR; ops[5] = OP_SLT; ops[6] = OP_ADDI;
      for (int k = 0; k < 16; k++) begin
         op = ops[$urandom_range(0, 6)];
         if (op == OP_ADDI)
            run_instr(enc_i(op, 2'($urandom), 2'($urandom), 8'($urandom)), bt);
         else
            run_instr(enc_r(op, 2'($urandom), 2'($urandom), 2'($urandom)), bt);
      end
      for (int i = 0; i < 4; i++) begin
         dbg_rsel = 2'(i); #1;
         checks++;
         if (dbg_rdata !== m_regs[i]) begin
            errors++; $display("FAIL random_regs R%0d: got %h expected %h", i, dbg_rdata, m_regs[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic bt;
      run_instr(enc_i(OP_ADDI, 2'd1, 2'd0, 8'd7), bt);
      run_instr(enc_i(OP_ADDI, 2'd2, 2'd0, 8'd7), bt);
      goto_pc(8'd10);
      run_instr(enc_i(OP_BEQ, 2'd1, 2'd2, 8'hFC), bt);
      checks++;
      if (bt !== 1'b1 || pc !== 8'd6) begin
         errors++; $display("FAIL beq_taken: taken=%b pc=%h expected 1 and 06", bt, pc);
      end
      goto_pc(8'd10);
      run_instr(enc_i(OP_BNE, 2'd1, 2'd2, 8'hFC), bt);
      checks++;
      if (bt !== 1'b0 || pc !== 8'd11) begin
         errors++; $display("FAIL bne_not_taken: taken=%b pc=%h expected 0 and 0b", bt, pc);
      end
   endtask

   task automatic test_wrap_and_cadence();
      logic       bt;
      logic [7:0] saved [4];
      int         base;
      goto_pc(8'd255);
      for (int i = 0; i < 4; i++) saved[i] = m_regs[i];
      run_instr(16'h7ABC, bt);
      checks++;
      if (pc !== 8'd0) begin
         errors++; $display("FAIL pc_wrap: pc=%h expected 00", pc);
      end
      for (int i = 0; i < 4; i++) begin
         dbg_rsel = 2'(i); #1;
         checks++;
         if (dbg_rdata !== saved[i]) begin
            errors++; $display("FAIL nop_regs R%0d: got %h expected %h", i, dbg_rdata, saved[i]);
         end
      end
      base = n_retire;
      instr_valid = 1'b1; instr = 16'h7000;
      for (int c = 0; c < 9; c++) begin
         checks++;
         if (instr_ready !== ((c % 3) == 0)) begin
            errors++; $display("FAIL ready_cadence c=%0d: got %b expected %b", c, instr_ready, (c % 3) == 0);
         end
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      m_pc = m_pc + 8'd3;
      checks++;
      if ((n_retire - base) != 3 || pc !== m_pc) begin
         errors++; $display("FAIL cadence_retire: retires=%0d pc=%h expected 3 and %h", n_retire - base, pc, m_pc);
      end
   endtask

   task automatic test_reset_abort();
      int base;
      // Abort in EXEC
      base = n_retire;
      instr_valid = 1'b1; instr = enc_i(OP_ADDI, 2'd1, 2'd0, 8'd9);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      rst = 1'b1; #1;
      checks++;
      if ({alu_opcode, alu_a, alu_b, retire, instr_ready} !== {4'hF, 8'h00, 8'h00, 2'b00}) begin
         errors++; $display("FAIL rst_in_exec_outputs: op=%h a=%h b=%h retire=%b ready=%b expected f 00 00 0 0",
                            alu_opcode, alu_a, alu_b, retire, instr_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0; #1;
      checks++;
      if (instr_ready !== 1'b1 || pc !== 8'd0) begin
         errors++; $display("FAIL rst_exec_release: ready=%b pc=%h expected 1 and 00", instr_ready, pc);
      end
      dbg_rsel = 2'd1; #1;
      checks++;
      if (dbg_rdata !== 8'd0 || n_retire != base) begin
         errors++; $display("FAIL rst_exec_abort: R1=%h retires=%0d expected 00 and 0", dbg_rdata, n_retire - base);
      end
      // Abort in WB
      instr_valid = 1'b1; instr = enc_i(OP_ADDI, 2'd2, 2'd0, 8'd4);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      checks++;
      if ({retire, branch_taken} !== 2'b00) begin
         errors++; $display("FAIL rst_in_wb_pulses: retire/taken=%b expected 00", {retire, branch_taken});
      end
      @(posedge clk); #1;
      rst = 1'b0; #1;
      dbg_rsel = 2'd2; #1;
      checks++;
      if (dbg_rdata !== 8'd0 || pc !== 8'd0 || n_retire != base) begin
         errors++; $display("FAIL rst_wb_abort: R2=%h pc=%h retires=%0d expected 00 00 0",
                            dbg_rdata, pc, n_retire - base);
      end
      for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
      m_pc = 8'd0;
   endtask

   task automatic test_back_to_back();
      logic bt;
      run_instr(enc_i(OP_ADDI, 2'd1, 2'd0, 8'h80), bt);
      run_instr(enc_r(OP_ADD, 2'd2, 2'd1, 2'd1), bt);
      run_instr(enc_i(OP_BEQ, 2'd2, 2'd0, 8'd2), bt);
      run_instr(enc_i(OP_BNE, 2'd1, 2'd0, 8'h10), bt);
      checks++;
      if (pc !== 8'h14) begin
         errors++; $display("FAIL back_to_back_pc: pc=%h expected 14", pc);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; dbg_rsel = 2'd0;
      m_pc = 8'd0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
      test_reset();
      test_arith();
      test_slt();
      test_random_alu();
      test_branch();
      test_wrap_and_cadence();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
